// File: rtl/aq_reduce_ctrl.sv
// Frame sequencer for the image reducer: validates START geometry, emits FSYNC then gated pixels, counts outputs.
// Registered outputs (1 cycle); S_READY is combinational and drops on the edge that accepts the last frame beat.
module aq_reduce_ctrl #(
    parameter int DRAIN_TIMEOUT = 1024
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        START,
    input  logic        ABORT,
    input  logic [15:0] CFG_ORG_X,
    input  logic [15:0] CFG_ORG_Y,
    input  logic [15:0] CFG_CNV_X,
    input  logic [15:0] CFG_CNV_Y,
    input  logic        S_VALID,
    output logic        S_READY,
    input  logic [31:0] S_DATA,
    output logic [15:0] ORG_X,
    output logic [15:0] ORG_Y,
    output logic [15:0] CNV_X,
    output logic [15:0] CNV_Y,
    output logic        DIN_WE,
    output logic        DIN_FSYNC,
    output logic [31:0] DIN,
    input  logic        DOUT_OE,
    input  logic        DOUT_LAST,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [1:0]  ERR_CODE,
    output logic [31:0] OUT_CNT
);
    localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LIMIT = TW'(DRAIN_TIMEOUT);

    typedef enum logic [1:0] {IDLE, SYNC, FEED, DRAIN} state_t;

    state_t        state, state_nxt;
    logic [31:0]   total_in, total_in_nxt;
    logic [31:0]   total_out, total_out_nxt;
    logic [31:0]   in_cnt, in_cnt_nxt;
    logic [TW-1:0] tcnt, tcnt_nxt;
    logic [15:0]   org_x_nxt, org_y_nxt, cnv_x_nxt, cnv_y_nxt;
    logic          din_we_nxt, din_fsync_nxt, done_nxt, err_nxt;
    logic [31:0]   din_nxt, out_cnt_nxt;
    logic [1:0]    err_code_nxt;

    logic          cfg_ok;
    logic          accept;
    logic [31:0]   out_cnt_sat;
    logic [31:0]   in_cnt_inc;
    logic [TW-1:0] tcnt_inc;

    // The reducer's last flag is advisory; frame completion is decided purely on count.
    logic unused_last;
    assign unused_last = DOUT_LAST;

    assign S_READY     = (state == FEED) && (in_cnt != total_in);
    assign accept      = S_VALID && S_READY;
    assign cfg_ok      = (CFG_ORG_X != 16'd0) && (CFG_ORG_Y != 16'd0) &&
                         (CFG_CNV_X != 16'd0) && (CFG_CNV_X <= CFG_ORG_X) &&
                         (CFG_CNV_Y != 16'd0) && (CFG_CNV_Y <= CFG_ORG_Y);
    assign out_cnt_sat = (OUT_CNT == 32'hFFFF_FFFF) ? OUT_CNT : OUT_CNT + 32'd1;
    assign in_cnt_inc  = in_cnt + 32'd1;
    assign tcnt_inc    = tcnt + TW'(1);

    always_comb begin
        state_nxt     = state;
        total_in_nxt  = total_in;
        total_out_nxt = total_out;
        in_cnt_nxt    = in_cnt;
        tcnt_nxt      = tcnt;
        org_x_nxt     = ORG_X;
        org_y_nxt     = ORG_Y;
        cnv_x_nxt     = CNV_X;
        cnv_y_nxt     = CNV_Y;
        din_we_nxt    = 1'b0;
        din_fsync_nxt = 1'b0;
        din_nxt       = DIN;
        done_nxt      = 1'b0;
        err_nxt       = 1'b0;
        err_code_nxt  = ERR_CODE;
        out_cnt_nxt   = OUT_CNT;

        // Reducer output can start while pixels are still being fed, so count in every active state.
        if (state != IDLE && DOUT_OE)
            out_cnt_nxt = out_cnt_sat;

        if (state != IDLE && ABORT) begin
            state_nxt    = IDLE;
            err_nxt      = 1'b1;
            err_code_nxt = 2'd3;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        if (cfg_ok) begin
                            org_x_nxt     = CFG_ORG_X;
                            org_y_nxt     = CFG_ORG_Y;
                            cnv_x_nxt     = CFG_CNV_X;
                            cnv_y_nxt     = CFG_CNV_Y;
                            total_in_nxt  = {16'd0, CFG_ORG_X} * {16'd0, CFG_ORG_Y};
                            total_out_nxt = {16'd0, CFG_CNV_X} * {16'd0, CFG_CNV_Y};
                            in_cnt_nxt    = 32'd0;
                            out_cnt_nxt   = 32'd0;
                            err_code_nxt  = 2'd0;
                            state_nxt     = SYNC;
                        end else begin
                            err_nxt      = 1'b1;
                            err_code_nxt = 2'd1;
                        end
                    end
                end
                SYNC: begin
                    din_fsync_nxt = 1'b1;
                    state_nxt     = FEED;
                end
                FEED: begin
                    if (accept) begin
                        din_nxt    = S_DATA;
                        din_we_nxt = 1'b1;
                        in_cnt_nxt = in_cnt_inc;
                        if (in_cnt_inc == total_in) begin
                            tcnt_nxt  = '0;
                            state_nxt = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // A count already reached during FEED completes here on the first DRAIN cycle.
                    if (out_cnt_nxt == total_out) begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else if (DOUT_OE) begin
                        tcnt_nxt = '0;
                    end else if (tcnt_inc == TO_LIMIT) begin
                        err_nxt      = 1'b1;
                        err_code_nxt = 2'd2;
                        state_nxt    = IDLE;
                    end else begin
                        tcnt_nxt = tcnt_inc;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            total_in  <= 32'd0;
            total_out <= 32'd0;
            in_cnt    <= 32'd0;
            tcnt      <= '0;
            ORG_X     <= 16'd0;
            ORG_Y     <= 16'd0;
            CNV_X     <= 16'd0;
            CNV_Y     <= 16'd0;
            DIN_WE    <= 1'b0;
            DIN_FSYNC <= 1'b0;
            DIN       <= 32'd0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            ERR       <= 1'b0;
            ERR_CODE  <= 2'd0;
            OUT_CNT   <= 32'd0;
        end else begin
            state     <= state_nxt;
            total_in  <= total_in_nxt;
            total_out <= total_out_nxt;
            in_cnt    <= in_cnt_nxt;
            tcnt      <= tcnt_nxt;
            ORG_X     <= org_x_nxt;
            ORG_Y     <= org_y_nxt;
            CNV_X     <= cnv_x_nxt;
            CNV_Y     <= cnv_y_nxt;
            DIN_WE    <= din_we_nxt;
            DIN_FSYNC <= din_fsync_nxt;
            DIN       <= din_nxt;
            BUSY      <= (state_nxt != IDLE);
            DONE      <= done_nxt;
            ERR       <= err_nxt;
            ERR_CODE  <= err_code_nxt;
            OUT_CNT   <= out_cnt_nxt;
        end
    end
endmodule

// File: tb/tb_aq_reduce_ctrl.sv
// Randomized frame-level bench for aq_reduce_ctrl against a timing/count model of the frame protocol.
module tb_aq_reduce_ctrl;
    localparam int TO = 16;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        START, ABORT;
    logic [15:0] CFG_ORG_X, CFG_ORG_Y, CFG_CNV_X, CFG_CNV_Y;
    logic        S_VALID, S_READY;
    logic [31:0] S_DATA;
    logic [15:0] ORG_X, ORG_Y, CNV_X, CNV_Y;
    logic        DIN_WE, DIN_FSYNC;
    logic [31:0] DIN;
    logic        DOUT_OE, DOUT_LAST;
    logic        BUSY, DONE, ERR;
    logic [1:0]  ERR_CODE;
    logic [31:0] OUT_CNT;

    int n_chk = 0;
    int n_bad = 0;

    aq_reduce_ctrl #(.DRAIN_TIMEOUT(TO)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .ABORT(ABORT),
        .CFG_ORG_X(CFG_ORG_X), .CFG_ORG_Y(CFG_ORG_Y), .CFG_CNV_X(CFG_CNV_X), .CFG_CNV_Y(CFG_CNV_Y),
        .S_VALID(S_VALID), .S_READY(S_READY), .S_DATA(S_DATA),
        .ORG_X(ORG_X), .ORG_Y(ORG_Y), .CNV_X(CNV_X), .CNV_Y(CNV_Y),
        .DIN_WE(DIN_WE), .DIN_FSYNC(DIN_FSYNC), .DIN(DIN),
        .DOUT_OE(DOUT_OE), .DOUT_LAST(DOUT_LAST),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .ERR_CODE(ERR_CODE), .OUT_CNT(OUT_CNT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_cfg(input int ox, input int oy, input int cx, input int cy);
        CFG_ORG_X = 16'(ox);
        CFG_ORG_Y = 16'(oy);
        CFG_CNV_X = 16'(cx);
        CFG_CNV_Y = 16'(cy);
    endtask

    // Frame model: edge 0 samples START; FSYNC follows edge 1; each accepted beat shows on DIN one edge later;
    // DONE at max(last_accept_edge+1, last_output_edge); timeout ERR at last_accept_edge+TO.
    task automatic run_frame(input int ox, input int oy, input int cx, input int cy,
                             input int vmode, input bit use_oe, input string nm);
        int tin, tout, acc, oes, e, last_acc, last_oe, gap, we_cnt, done_at;
        bit fin, exp_we, exp_rdy, exp_done, exp_err, v;
        logic [31:0] exp_dat;
        tin = ox * oy; tout = cx * cy;
        acc = 0; oes = 0; e = 0; last_acc = -1; last_oe = -1; gap = 0; we_cnt = 0;
        fin = 0; exp_we = 0; exp_dat = 32'd0;
        set_cfg(ox, oy, cx, cy);
        START = 1'b1;
        tick();
        START = 1'b0;
        while (!fin && e < 3000) begin
            done_at  = (last_acc + 1 > last_oe) ? last_acc + 1 : last_oe;
            exp_done = use_oe && last_acc >= 0 && last_oe >= 0 && e == done_at;
            exp_err  = !use_oe && last_acc >= 0 && e == last_acc + TO;
            exp_rdy  = (e >= 1) && (acc < tin);
            chk({nm, "/din_we"}, 32'(DIN_WE), 32'(exp_we));
            if (exp_we) chk({nm, "/din"}, DIN, exp_dat);
            if (DIN_WE) we_cnt++;
            chk({nm, "/fsync"}, 32'(DIN_FSYNC), 32'(e == 1));
            chk({nm, "/out_cnt"}, OUT_CNT, 32'(oes));
            chk({nm, "/done"}, 32'(DONE), 32'(exp_done));
            chk({nm, "/err"}, 32'(ERR), 32'(exp_err));
            chk({nm, "/busy"}, 32'(BUSY), 32'(!(exp_done || exp_err)));
            chk({nm, "/s_ready"}, 32'(S_READY), 32'(exp_rdy));
            if (e == 0) begin
                chk({nm, "/org_x"}, 32'(ORG_X), 32'(ox));
                chk({nm, "/cnv_y"}, 32'(CNV_Y), 32'(cy));
                chk({nm, "/err_code_clr"}, 32'(ERR_CODE), 32'd0);
            end
            if (exp_err) chk({nm, "/err_code"}, 32'(ERR_CODE), 32'd2);
            if (exp_done || exp_err) begin
                fin = 1'b1;
            end else begin
                CFG_ORG_X = 16'($urandom);
                CFG_CNV_Y = 16'($urandom);
                case (vmode)
                    0:       v = 1'b1;
                    1:       v = (e % 2 == 0);
                    default: v = ($urandom_range(0, 1) == 1);
                endcase
                S_VALID = v;
                S_DATA  = $urandom;
                exp_we  = v && exp_rdy;
                if (exp_we) begin
                    exp_dat = S_DATA;
                    acc++;
                    if (acc == tin) last_acc = e + 1;
                end
                if (use_oe && oes < tout)
                    DOUT_OE = ($urandom_range(0, 2) == 0) || (acc == tin && gap >= 3);
                else
                    DOUT_OE = 1'b0;
                DOUT_LAST = DOUT_OE && ($urandom_range(0, 3) == 0);
                if (DOUT_OE) begin
                    oes++;
                    gap = 0;
                    if (oes == tout) last_oe = e + 1;
                end else begin
                    gap++;
                end
                tick();
                e++;
            end
        end
        S_VALID = 1'b0; DOUT_OE = 1'b0; DOUT_LAST = 1'b0;
        chk({nm, "/finished"}, 32'(fin), 32'd1);
        chk({nm, "/we_total"}, 32'(we_cnt), 32'(tin));
        chk({nm, "/org_y_held"}, 32'(ORG_Y), 32'(oy));
        chk({nm, "/cnv_x_held"}, 32'(CNV_X), 32'(cx));
    endtask

    task automatic bad_cfg(input int ox, input int oy, input int cx, input int cy, input string nm);
        set_cfg(ox, oy, cx, cy);
        START = 1'b1;
        tick();
        START = 1'b0;
        chk({nm, "/err"}, 32'(ERR), 32'd1);
        chk({nm, "/err_code"}, 32'(ERR_CODE), 32'd1);
        chk({nm, "/busy"}, 32'(BUSY), 32'd0);
        chk({nm, "/fsync"}, 32'(DIN_FSYNC), 32'd0);
        tick();
        chk({nm, "/err_pulse"}, 32'(ERR), 32'd0);
        chk({nm, "/err_code_hold"}, 32'(ERR_CODE), 32'd1);
        chk({nm, "/busy2"}, 32'(BUSY), 32'd0);
        chk({nm, "/fsync2"}, 32'(DIN_FSYNC), 32'd0);
        chk({nm, "/s_ready"}, 32'(S_READY), 32'd0);
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "/busy"}, 32'(BUSY), 32'd0);
        chk({nm, "/s_ready"}, 32'(S_READY), 32'd0);
        chk({nm, "/din_we"}, 32'(DIN_WE), 32'd0);
        chk({nm, "/fsync"}, 32'(DIN_FSYNC), 32'd0);
        chk({nm, "/din"}, DIN, 32'd0);
        chk({nm, "/done"}, 32'(DONE), 32'd0);
        chk({nm, "/err"}, 32'(ERR), 32'd0);
        chk({nm, "/err_code"}, 32'(ERR_CODE), 32'd0);
        chk({nm, "/out_cnt"}, OUT_CNT, 32'd0);
        chk({nm, "/org_x"}, 32'(ORG_X), 32'd0);
        chk({nm, "/cnv_y"}, 32'(CNV_Y), 32'd0);
    endtask

    initial begin
        int ox, oy, cx, cy;
        RST_N = 1'b0; START = 1'b0; ABORT = 1'b0;
        S_VALID = 1'b0; S_DATA = 32'd0; DOUT_OE = 1'b0; DOUT_LAST = 1'b0;
        set_cfg(0, 0, 0, 0);
        repeat (2) @(posedge CLK);
        #1;
        check_all_zero("reset");
        RST_N = 1'b1;
        tick();

        run_frame(4, 4, 2, 2, 0, 1'b1, "basic");
        run_frame(8, 2, 3, 1, 1, 1'b1, "throttle");
        bad_cfg(4, 4, 5, 2, "bad_cnvx");
        bad_cfg(4, 0, 2, 1, "bad_orgy");
        bad_cfg(3, 3, 0, 1, "bad_cnv0");
        run_frame(2, 2, 1, 1, 0, 1'b0, "timeout");
        tick();

        // Abort after five accepted beats, with a START in the same cycle.
        set_cfg(4, 4, 2, 2);
        START = 1'b1;
        tick();
        START = 1'b0;
        S_VALID = 1'b1;
        repeat (6) begin
            S_DATA = $urandom;
            tick();
        end
        chk("abort/pre_we", 32'(DIN_WE), 32'd1);
        ABORT = 1'b1; START = 1'b1;
        tick();
        ABORT = 1'b0; START = 1'b0;
        chk("abort/din_we", 32'(DIN_WE), 32'd0);
        chk("abort/s_ready", 32'(S_READY), 32'd0);
        chk("abort/err", 32'(ERR), 32'd1);
        chk("abort/err_code", 32'(ERR_CODE), 32'd3);
        chk("abort/busy", 32'(BUSY), 32'd0);
        chk("abort/org_x", 32'(ORG_X), 32'd4);
        chk("abort/cnv_x", 32'(CNV_X), 32'd2);
        tick();
        chk("abort/start_ignored", 32'(BUSY), 32'd0);
        chk("abort/no_fsync", 32'(DIN_FSYNC), 32'd0);
        chk("abort/err_pulse", 32'(ERR), 32'd0);
        chk("abort/s_ready2", 32'(S_READY), 32'd0);
        S_VALID = 1'b0;
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        chk("abort_idle/err", 32'(ERR), 32'd0);
        chk("abort_idle/err_code", 32'(ERR_CODE), 32'd3);

        // Async reset while draining, with one output already counted.
        set_cfg(2, 2, 2, 1);
        START = 1'b1;
        tick();
        START = 1'b0;
        S_VALID = 1'b1;
        DOUT_OE = 1'b1;
        for (int i = 0; i < 7; i++) begin
            S_DATA = $urandom;
            tick();
            DOUT_OE = 1'b0;
        end
        S_VALID = 1'b0;
        chk("rst/pre_busy", 32'(BUSY), 32'd1);
        chk("rst/pre_out_cnt", OUT_CNT, 32'd1);
        #2 RST_N = 1'b0;
        #1 check_all_zero("rst_mid");
        #2 RST_N = 1'b1;
        tick();
        run_frame(2, 2, 1, 1, 0, 1'b1, "post_rst");

        for (int k = 0; k < 8; k++) begin
            ox = $urandom_range(1, 6);
            oy = $urandom_range(1, 4);
            cx = $urandom_range(1, ox);
            cy = $urandom_range(1, oy);
            run_frame(ox, oy, cx, cy, $urandom_range(0, 2), 1'b1, $sformatf("rand%0d", k));
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/aq_reduce_ctrl.md
Name: aq_reduce_ctrl

Overview:
Frame sequencer for the image reduction datapath. Accepts a software START with frame geometry and validates it. Holds ORG/CNV stable for the whole frame and generates the FSYNC-then-pixel sequence the reducer needs. Gates a valid/ready pixel source into the reducer's DIN_WE/DIN interface, counts reduced output pixels, and reports DONE, ERR and status.

Parameters:
DRAIN_TIMEOUT, 1024, max cycles in DRAIN without a DOUT_OE before ERR (timeout code).

Ports:
CLK  in  1  clock
RST_N  in  1  asynchronous active-low reset
START  in  1  one-cycle frame start request; honoured only in IDLE
ABORT  in  1  one-cycle abort; highest priority
CFG_ORG_X  in  16  source width
CFG_ORG_Y  in  16  source height
CFG_CNV_X  in  16  reduced width
CFG_CNV_Y  in  16  reduced height
S_VALID  in  1  source pixel valid
S_READY  out  1  source pixel accept
S_DATA  in  32  source pixel ARGB
ORG_X, ORG_Y, CNV_X, CNV_Y  out  16 each  latched geometry to reducer
DIN_WE  out  1  pixel strobe to reducer
DIN_FSYNC  out  1  frame sync to reducer
DIN  out  32  pixel data to reducer
DOUT_OE  in  1  reducer output strobe
DOUT_LAST  in  1  reducer last flag
BUSY  out  1  state != IDLE
DONE  out  1  one-cycle frame-complete pulse
ERR  out  1  one-cycle error pulse
ERR_CODE  out  2  1=bad config, 2=drain timeout, 3=aborted; held until next START
OUT_CNT  out  32  output pixels counted this frame

Behaviour:
- Reset: S_READY, DIN_WE, DIN_FSYNC, BUSY, DONE, ERR = 0. DIN, ORG_*, CNV_*, OUT_CNT = 0. ERR_CODE = 0. State IDLE.
- All outputs are registered except S_READY. S_READY = (state == FEED) & (in_cnt != total_in).
- States: IDLE, SYNC, FEED, DRAIN.
- IDLE + START:
  - Config is valid when ORG_X != 0, ORG_Y != 0, 1 <= CNV_X <= ORG_X, and 1 <= CNV_Y <= ORG_Y.
  - Valid config: latch CFG_* into ORG_*/CNV_*, compute total_in = ORG_X*ORG_Y and total_out = CNV_X*CNV_Y (32-bit unsigned), clear in_cnt and OUT_CNT, clear ERR_CODE, go to SYNC.
  - Invalid config: ERR pulses next cycle, ERR_CODE = 1, stay in IDLE.
- SYNC (exactly 1 cycle): DIN_FSYNC = 1 and DIN_WE = 0 on the following cycle; then go to FEED. FSYNC therefore always leads the first DIN_WE by at least 1 cycle.
- FEED:
  - Each cycle with S_VALID & S_READY: DIN <= S_DATA and DIN_WE <= 1 on the next cycle; in_cnt increments. Otherwise DIN_WE <= 0 and DIN holds.
  - When the accepted beat makes in_cnt == total_in, go to DRAIN. S_READY drops on that same edge, so no extra beat is ever accepted.
  - Back-to-back beats are sustained at 1 pixel/clock.
- DOUT_OE is monitored in every non-IDLE state, since outputs can overlap FEED. Each DOUT_OE increments OUT_CNT (saturating at 0xFFFFFFFF).
- DRAIN:
  - A timeout counter resets on each DOUT_OE and otherwise increments.
  - When OUT_CNT (including the current beat) == total_out: DONE pulses, go to IDLE.
  - When the timeout counter reaches DRAIN_TIMEOUT: ERR pulses, ERR_CODE = 2, go to IDLE.
- DONE and the final DOUT_OE counted: if total_out is reached while still in FEED, DONE is deferred until entry to DRAIN, then pulses on the first DRAIN cycle.
- DOUT_LAST is informational only. If it arrives with OUT_CNT+1 != total_out, the frame still completes on count; no error is raised.
- ABORT in any non-IDLE state:
  - Next cycle: DIN_WE = 0, DIN_FSYNC = 0, S_READY = 0, ERR pulses with ERR_CODE = 3, state IDLE.
  - ORG_*/CNV_* hold their values.
  - ABORT in IDLE is ignored. ABORT and START in the same cycle: ABORT wins, START is ignored.
- START outside IDLE is ignored.
- CFG_* changes outside IDLE have no effect until the next START.
- Async reset mid-frame: all state clears immediately; the next frame is started by a fresh START.

Test Plan:
- Basic frame: CFG 4x4 -> 2x2, START, S_VALID held high. Required: DIN_FSYNC at cycle START+2; DIN_WE high for 16 consecutive cycles starting START+3; S_READY low after 16 accepts; DONE once, when OUT_CNT = 4.
- Throttled source: 8x2 -> 3x1, with S_VALID toggling every other cycle. Required: exactly 16 DIN_WE pulses, DIN equals the accepted S_DATA in order, and DONE when OUT_CNT = 3.
- Bad config: CNV_X = 5 with ORG_X = 4, then separately ORG_Y = 0. Required: ERR pulse with ERR_CODE = 1, BUSY stays 0, and no DIN_FSYNC.
- Drain timeout: 2x2 -> 1x1, DOUT_OE never asserted, DRAIN_TIMEOUT = 16. Required: ERR with ERR_CODE = 2 exactly 16 cycles after DRAIN entry; BUSY then 0.
- Abort mid-FEED after 5 beats of 4x4, with START pulsed in the same cycle. Required: next cycle DIN_WE = 0 and S_READY = 0, ERR_CODE = 3, state IDLE, and the simultaneous START is ignored.
- Async reset mid-DRAIN. Required: all outputs 0 immediately; a new START of 2x2 -> 1x1 completes normally with OUT_CNT = 1.
